// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: default sizes,
// FSM state encoding and a small modulo helper used by the picker and the top.
package mux_rr_arbiter_pkg;

    localparam int N_REQ_DEF     = 5;
    localparam int CTRL_W_DEF    = 3;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Index arithmetic around the requester ring.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first set request bit found by
// scanning start, start+1, ... with wrap-around. Purely combinational so the
// same logic serves both IDLE arbitration and re-arbitration on release.
module mux_rr_arbiter_rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [CTRL_W-1:0] start,
    output logic              found,
    output logic [CTRL_W-1:0] idx
);

    logic [CTRL_W-1:0] cand;

    // Scan the ring once from start; the first hit wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise a path
        // that skips an assignment infers a latch.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = CTRL_W'(wrap_add(int'(start), i, N_REQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a 5-input data mux. A grant is
// held for up to BURST_LEN accepted words (valid & ready), then the ring is
// re-arbitrated in the same cycle so a new winner follows with no bubble.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [N_REQ-1:0]  o_grant,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ptr_q, ptr_d;

    logic              busy;
    logic              xfer;
    logic              release_g;
    logic [CTRL_W-1:0] pick_start;
    logic              pick_found;
    logic [CTRL_W-1:0] pick_idx;

    assign busy = (state_q == ST_GRANT);
    assign xfer = o_valid & i_ready;

    // Current owner gives up the grant when it drops its request or finishes its burst.
    assign release_g = busy & (~i_req[ctrl_q] | (xfer & (cnt_q == CNT_LAST)));

    // While granted, the owner becomes last-served on release, so scan from g+1;
    // when idle, scan from the stored last-served pointer.
    assign pick_start = CTRL_W'(wrap_add(int'(busy ? ctrl_q : ptr_q), 1, N_REQ));

    mux_rr_arbiter_rr_pick #(
        .N_REQ  (N_REQ),
        .CTRL_W (CTRL_W)
    ) u_pick (
        .req   (i_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register: FSM state, select, grant, burst counter and last-served pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= CTRL_W'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: grant from IDLE, count transfers, release and re-arbitrate.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    ctrl_d  = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_g) begin
                    ptr_d = ctrl_q;
                    cnt_d = '0;
                    if (pick_found) begin
                        ctrl_d  = pick_idx;
                        grant_d = N_REQ'(1) << pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: registered select/grant, combinational valid so a dropped request
    // is seen downstream in the same cycle.
    always_comb begin
        o_busy  = busy;
        o_valid = busy & i_req[ctrl_q];
        o_ctrl  = ctrl_q;
        o_grant = grant_q;
    end

endmodule
